// File: rtl/dcache_refill_ctrl_if.sv
// Main-memory beat bus between the refill engine (master) and memory (slave).
// Handshake: a beat completes in any cycle where o_mem_req and i_mem_ack are both 1;
// address/we/wdata hold until then, and an ack while o_mem_req=0 is ignored.
interface dcache_refill_ctrl_if;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Data-cache refill engine: optional dirty-victim writeback, then a 4-word line
// fetch written into the four columns through a one-hot fill write enable.
module dcache_refill_ctrl #(
  parameter  int INDEX_BITS = 3,
  localparam int TAG_BITS   = 32 - INDEX_BITS - 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_miss_req,
  input  logic [31:0]           i_miss_addr,
  input  logic                  i_dirty,
  input  logic [TAG_BITS-1:0]   i_victim_tag,
  input  logic [127:0]          i_line_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [INDEX_BITS-1:0] o_index,
  output logic [3:0]            o_weB,
  output logic [31:0]           o_fill_data,
  output logic [1:0]            o_dbg_state,
  dcache_refill_ctrl_if.master  mem
);

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            k_q, k_d;
  logic [TAG_BITS-1:0]   miss_tag_q;
  logic [INDEX_BITS-1:0] index_q;
  logic [TAG_BITS-1:0]   victim_tag_q;
  logic [127:0]          line_q;
  logic [3:0]            weB_q;
  logic [31:0]           fill_q;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^i_miss_addr[3:0];

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (i_miss_req) begin
          state_d = i_dirty ? S_WB : S_FILL;
          k_d     = 2'd0;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag_q, index_q, k_q, 2'b00};
        mem_wdata = line_q[{k_q, 5'd0} +: 32];
        if (mem.i_mem_ack) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = S_FILL;
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, index_q, k_q, 2'b00};
        if (mem.i_mem_ack) begin
          k_d = k_q + 2'd1;
          if (k_q == 2'd3) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Victim line is buffered at accept so column writes during the refill cannot corrupt it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= 2'd0;
      miss_tag_q   <= '0;
      index_q      <= '0;
      victim_tag_q <= '0;
      line_q       <= '0;
      weB_q        <= 4'b0000;
      fill_q       <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (state_q == S_IDLE && i_miss_req) begin
        miss_tag_q   <= i_miss_addr[31:INDEX_BITS+4];
        index_q      <= i_miss_addr[INDEX_BITS+3:4];
        victim_tag_q <= i_victim_tag;
        line_q       <= i_line_data;
      end
      weB_q <= 4'b0000;
      if (state_q == S_FILL && mem.i_mem_ack) begin
        weB_q  <= 4'b0001 << k_q;
        fill_q <= mem.i_mem_rdata;
      end
    end
  end

  assign mem.o_mem_req   = mem_req;
  assign mem.o_mem_we    = mem_we;
  assign mem.o_mem_addr  = mem_addr;
  assign mem.o_mem_wdata = mem_wdata;

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_index     = index_q;
  assign o_weB       = weB_q;
  assign o_fill_data = fill_q;
  assign o_dbg_state = state_q;

endmodule
